wb_merge: RTL and testbench

WB_MERGE -- requirements
Module: wb_merge

---
 rtl/wb_merge.sv | 131 +++++++++++++
 tb/tb_wb_merge.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_merge.sv
// wb_merge: merges NUM_PORTS one-deep writeback holding entries into a single registered packet stream.
// Config macro WB_MERGE_RR_EN selects round-robin arbitration; undefined gives fixed lowest-index priority.
module wb_merge #(
  parameter int NUM_PORTS = 3,
  parameter int ID_W      = 3,
  parameter int DATA_W    = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          unit_valid,
  input  logic [NUM_PORTS*ID_W-1:0]     unit_id,
  input  logic [NUM_PORTS*DATA_W-1:0]   unit_data,
  output logic [NUM_PORTS-1:0]          unit_ack,
  output logic                          wb_valid,
  output logic [ID_W-1:0]               wb_id,
  output logic [DATA_W-1:0]             wb_data,
  input  logic                          wb_ready
);

  logic [NUM_PORTS-1:0]             hold_valid_q, hold_valid_d;
  logic [NUM_PORTS-1:0][ID_W-1:0]   hold_id_q, hold_id_d;
  logic [NUM_PORTS-1:0][DATA_W-1:0] hold_data_q, hold_data_d;
  logic                             wb_valid_q, wb_valid_d;
  logic [ID_W-1:0]                  wb_id_q, wb_id_d;
  logic [DATA_W-1:0]                wb_data_q, wb_data_d;

  logic [NUM_PORTS-1:0] grant;
  logic [NUM_PORTS-1:0] grant_fire;
  logic                 gnt_found;
  logic                 out_free;

`ifdef WB_MERGE_RR_EN
  localparam int PTR_W = $clog2(NUM_PORTS);
  logic [PTR_W-1:0] ptr_q, ptr_d, gnt_idx;

  // Two passes: indices at/after the pointer first, then wrap to the low indices.
  always_comb begin
    grant     = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!gnt_found && hold_valid_q[i] && (PTR_W'(i) >= ptr_q)) begin
        grant[i]  = 1'b1;
        gnt_idx   = PTR_W'(i);
        gnt_found = 1'b1;
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!gnt_found && hold_valid_q[i]) begin
        grant[i]  = 1'b1;
        gnt_idx   = PTR_W'(i);
        gnt_found = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (|grant_fire) begin
      ptr_d = (gnt_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  always_comb begin
    grant     = '0;
    gnt_found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!gnt_found && hold_valid_q[i]) begin
        grant[i]  = 1'b1;
        gnt_found = 1'b1;
      end
    end
  end
`endif

  assign out_free   = !wb_valid_q || wb_ready;
  assign grant_fire = grant & {NUM_PORTS{out_free}};
  assign unit_ack   = ~hold_valid_q | grant_fire;

  // A drained entry may be refilled on the same edge; the load below wins over the clear.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_id_d    = hold_id_q;
    hold_data_d  = hold_data_q;
    wb_valid_d   = wb_valid_q;
    wb_id_d      = wb_id_q;
    wb_data_d    = wb_data_q;
    if (wb_ready) wb_valid_d = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_fire[i]) begin
        wb_valid_d      = 1'b1;
        wb_id_d         = hold_id_q[i];
        wb_data_d       = hold_data_q[i];
        hold_valid_d[i] = 1'b0;
      end
      if (unit_valid[i] && unit_ack[i]) begin
        hold_valid_d[i] = 1'b1;
        hold_id_d[i]    = unit_id[i*ID_W +: ID_W];
        hold_data_d[i]  = unit_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_q <= '0;
      hold_id_q    <= '0;
      hold_data_q  <= '0;
      wb_valid_q   <= 1'b0;
      wb_id_q      <= '0;
      wb_data_q    <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_id_q    <= hold_id_d;
      hold_data_q  <= hold_data_d;
      wb_valid_q   <= wb_valid_d;
      wb_id_q      <= wb_id_d;
      wb_data_q    <= wb_data_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_id    = wb_id_q;
  assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_wb_merge.sv
// Bench for wb_merge: per-port packet queues model the merge, checked every cycle, plus directed scenarios.
module tb_wb_merge;
  localparam int NP  = 3;
  localparam int IDW = 3;
  localparam int DW  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NP-1:0]     unit_valid = '0;
  logic [NP*IDW-1:0] unit_id = '0;
  logic [NP*DW-1:0]  unit_data = '0;
  logic [NP-1:0]     unit_ack;
  logic              wb_valid;
  logic [IDW-1:0]    wb_id;
  logic [DW-1:0]     wb_data;
  logic              wb_ready = 1'b0;

  wb_merge #(.NUM_PORTS(NP), .ID_W(IDW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .unit_valid(unit_valid), .unit_id(unit_id), .unit_data(unit_data),
    .unit_ack(unit_ack), .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data), .wb_ready(wb_ready)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
  } pkt_t;

  int   total = 0;
  int   bad = 0;
  pkt_t mq[NP][$];
  bit   m_valid = 1'b0;
  pkt_t m_out = '0;
  int   m_ptr = 0;
  int   pushes = 0;
  int   consumed = 0;
  int   valid_cnt = 0;
  pkt_t wlog[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Next port to be served: first non-empty queue, scanning from the rotating pointer or from 0.
  function automatic int m_pick();
    for (int k = 0; k < NP; k++) begin
      int j;
`ifdef WB_MERGE_RR_EN
      j = (m_ptr + k) % NP;
`else
      j = k;
`endif
      if (mq[j].size() != 0) return j;
    end
    return -1;
  endfunction

  function automatic bit m_ack(int i);
    bit free;
    free = !m_valid || wb_ready;
    return (mq[i].size() == 0) || (free && (m_pick() == i));
  endfunction

  task automatic model_step();
    bit [NP-1:0] ack;
    bit          free;
    int          p;
    pkt_t        pk;
    free = !m_valid || wb_ready;
    p    = m_pick();
    for (int i = 0; i < NP; i++) ack[i] = m_ack(i);
    if (free && p >= 0) begin
      m_out   = mq[p].pop_front();
      m_valid = 1'b1;
      m_ptr   = (p + 1) % NP;
    end else if (wb_ready) begin
      m_valid = 1'b0;
    end
    for (int i = 0; i < NP; i++) begin
      if (unit_valid[i] && ack[i]) begin
        pk.id   = unit_id[i*IDW +: IDW];
        pk.data = unit_data[i*DW +: DW];
        mq[i].push_back(pk);
        pushes++;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      for (int i = 0; i < NP; i++) mq[i].delete();
      m_valid = 1'b0;
      m_out   = '0;
      m_ptr   = 0;
      pushes  = 0;
    end else begin
      model_step();
    end
  end

  initial forever begin
    logic [NP-1:0] ea;
    @(negedge clk);
    if (rst) begin
      chk("rst_ack", 64'(unit_ack), 64'({NP{1'b1}}));
      chk("rst_wb_valid", 64'(wb_valid), 64'(0));
      consumed = 0;
    end else begin
      for (int i = 0; i < NP; i++) ea[i] = m_ack(i);
      chk("model_ack", 64'(unit_ack), 64'(ea));
      chk("model_wb_valid", 64'(wb_valid), 64'(m_valid));
      if (m_valid) begin
        chk("model_wb_id", 64'(wb_id), 64'(m_out.id));
        chk("model_wb_data", 64'(wb_data), 64'(m_out.data));
      end
      if (wb_valid) valid_cnt++;
      if (wb_valid && wb_ready) begin
        wlog.push_back({wb_id, wb_data});
        consumed++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    unit_valid = '0;
    wb_ready   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    wlog.delete();
    valid_cnt = 0;
  endtask

  task automatic set_port(input int i, input logic [IDW-1:0] id, input logic [DW-1:0] d);
    unit_id[i*IDW +: IDW] = id;
    unit_data[i*DW +: DW] = d;
  endtask

  task automatic chk_log(input string name, input int idx, input logic [IDW-1:0] id, input logic [DW-1:0] d);
    if (wlog.size() > idx) begin
      chk({name, "_id"}, 64'(wlog[idx].id), 64'(id));
      chk({name, "_data"}, 64'(wlog[idx].data), 64'(d));
    end else begin
      chk({name, "_missing"}, 64'(wlog.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, iters;
    logic acc;
    logic [IDW-1:0] eid [4];
    logic [DW-1:0]  edat [4];

    @(negedge clk);
    chk("reset_wb_id", 64'(wb_id), 64'(0));
    chk("reset_wb_data", 64'(wb_data), 64'(0));
    chk("reset_ack_lit", 64'(unit_ack), 64'(3'b111));
    @(posedge clk);
    #2 rst = 1'b0;

    // single push on port 1
    apply_reset();
    wb_ready = 1'b1;
    step();
    unit_valid = 3'b010;
    set_port(1, 3'd5, 32'hDEADBEEF);
    step();
    unit_valid = '0;
    @(negedge clk);
    chk("single_not_yet", 64'(wb_valid), 64'(0));
    @(negedge clk);
    chk("single_valid", 64'(wb_valid), 64'(1));
    chk("single_id", 64'(wb_id), 64'(5));
    chk("single_data", 64'(wb_data), 64'(32'hDEADBEEF));
    @(negedge clk);
    chk("single_gone", 64'(wb_valid), 64'(0));
    repeat (3) step();
    chk("single_cycles", 64'(valid_cnt), 64'(1));
    chk("single_log", 64'(wlog.size()), 64'(1));

    // three ports at once
    apply_reset();
    wb_ready = 1'b1;
    step();
    unit_valid = 3'b111;
    for (int i = 0; i < NP; i++) set_port(i, IDW'(i + 1), DW'(32'h100 + i));
    step();
    unit_valid = '0;
    repeat (5) step();
    chk("three_count", 64'(wlog.size()), 64'(3));
    for (int i = 0; i < NP; i++) chk_log("three_order", i, IDW'(i + 1), DW'(32'h100 + i));

    // ports 0 and 2 refilled continuously
    apply_reset();
    wb_ready = 1'b1;
    step();
    unit_valid = 3'b101;
    for (int c = 0; c < 8; c++) begin
      set_port(0, 3'd0, DW'(32'hA00 + c));
      set_port(2, 3'd2, DW'(32'hB00 + c));
      step();
    end
    unit_valid = '0;
    repeat (8) step();
    for (int c = 0; c < 6; c++) begin
`ifdef WB_MERGE_RR_EN
      chk("refill_port", (wlog.size() > c) ? 64'(wlog[c].id) : 64'hFF, (c % 2 == 0) ? 64'(0) : 64'(2));
`else
      chk("refill_port", (wlog.size() > c) ? 64'(wlog[c].id) : 64'hFF, 64'(0));
`endif
    end

    // backpressure with all entries full
    apply_reset();
    step();
    wb_ready   = 1'b0;
    unit_valid = 3'b111;
    set_port(0, 3'd4, 32'hC0);
    set_port(1, 3'd5, 32'hC1);
    set_port(2, 3'd6, 32'hC2);
    step();
    set_port(0, 3'd7, 32'hC3);
    step();
    unit_valid = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_ack", 64'(unit_ack), 64'(0));
      chk("stall_valid", 64'(wb_valid), 64'(1));
      chk("stall_id", 64'(wb_id), 64'(4));
      chk("stall_data", 64'(wb_data), 64'(32'hC0));
    end
    @(posedge clk);
    #1 wb_ready = 1'b1;
    repeat (6) step();
    chk("stall_count", 64'(wlog.size()), 64'(4));
`ifdef WB_MERGE_RR_EN
    eid  = '{3'd4, 3'd5, 3'd6, 3'd7};
    edat = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
`else
    eid  = '{3'd4, 3'd7, 3'd5, 3'd6};
    edat = '{32'hC0, 32'hC3, 32'hC1, 32'hC2};
`endif
    for (int i = 0; i < 4; i++) chk_log("stall_drain", i, eid[i], edat[i]);

    // port 0 streaming 0..9
    apply_reset();
    wb_ready = 1'b1;
    step();
    k = 0;
    iters = 0;
    while (k < 10 && iters < 40) begin
      unit_valid = 3'b001;
      set_port(0, IDW'(k), DW'(k));
      @(negedge clk);
      acc = unit_ack[0];
      @(posedge clk);
      #1;
      if (acc) k++;
      iters++;
    end
    unit_valid = '0;
    repeat (4) step();
    chk("stream_cycles", 64'(iters), 64'(10));
    chk("stream_count", 64'(wlog.size()), 64'(10));
    for (int i = 0; i < 10; i++) chk_log("stream", i, IDW'(i), DW'(i));

    // asynchronous reset mid-cycle with output and two entries occupied
    apply_reset();
    step();
    unit_valid = 3'b111;
    for (int i = 0; i < NP; i++) set_port(i, IDW'(i + 1), DW'(32'hE0 + i));
    step();
    unit_valid = '0;
    step();
    @(negedge clk);
    chk("arst_pre_valid", 64'(wb_valid), 64'(1));
    #2 rst = 1'b1;
    unit_valid = 3'b111;
    #1;
    chk("arst_valid_now", 64'(wb_valid), 64'(0));
    chk("arst_ack_now", 64'(unit_ack), 64'(3'b111));
    @(posedge clk);
    @(posedge clk);
    #2 unit_valid = '0;
    rst = 1'b0;
    wb_ready  = 1'b1;
    valid_cnt = 0;
    wlog.delete();
    repeat (6) step();
    chk("arst_no_stale", 64'(valid_cnt), 64'(0));
    chk("arst_log", 64'(wlog.size()), 64'(0));

    // randomized traffic against the queue model
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      unit_valid = NP'($urandom_range(0, 7));
      for (int i = 0; i < NP; i++) set_port(i, IDW'($urandom), $urandom);
      wb_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    unit_valid = '0;
    wb_ready   = 1'b1;
    repeat (12) step();
    chk("random_conservation", 64'(consumed), 64'(pushes));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
